// File: rtl/ospi_pkg.sv
// Shared definitions for the octal-SPI target: opcodes, FSM state type and
// the device-ID byte selector.
package ospi_pkg;

    localparam logic [7:0] OP_READ    = 8'h0B;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_READ_ID = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } ospi_tgt_state_e;

    // ID bytes go out MSB first; anything past the third byte reads as zero.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [7:0] idx);
        logic [7:0] b;
        case (idx)
            8'd0:    b = id[23:16];
            8'd1:    b = id[15:8];
            8'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ospi_sclk_edge.sv
// Detects sclk edges in the clk domain. sclk is clk-synchronous, so a single
// history register is enough; rise/fall are valid in the cycle after sclk moves.
module ospi_sclk_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    output logic rise,
    output logic fall
);

    logic sclk_q;

    // One-cycle history of sclk for edge comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk;
        end
    end

    assign rise = sclk & ~sclk_q;
    assign fall = ~sclk & sclk_q;

endmodule

// File: rtl/ospi_target.sv
// Octal-SPI flash-like target. Decodes an SDR opcode/address frame framed by
// cs_n, serves READ/WRITE from an internal byte memory and READ_ID from a
// constant. Bus protocol: host presents dq on sclk rise (sampled on the
// detected rise); the target updates dq_o/dqs_o on each detected fall during
// read data and the host samples on the following rise. cs_n high aborts any
// frame and always wins over a coincident sclk edge.
module ospi_target
    import ospi_pkg::*;
#(
    parameter int          MEM_DEPTH    = 256,
    parameter int          ADDR_BYTES   = 4,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] DEVICE_ID    = 24'hC2853A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic [7:0] dq_i,
    output logic [7:0] dq_o,
    output logic       dq_oe,
    output logic       dqs_o,
    output logic       dqs_oe,
    output logic       err_cmd,
    output logic       busy
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = 8;

    ospi_tgt_state_e state;
    ospi_tgt_state_e state_next;

    logic          rise;
    logic          fall;
    logic          cs_n_q;
    logic [7:0]    op_q;
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
    logic [7:0]    mem [MEM_DEPTH];

    logic shift_addr;
    logic cnt_step;
    logic rd_load;
    logic wr_en;
    logic enter_ignore;

    ospi_sclk_edge u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; cs_n high returns every active state to IDLE.
    always_comb begin
        state_next = state;
        if (state != ST_IDLE && cs_n) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs_n && cs_n_q) state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (rise) begin
                        case (dq_i)
                            OP_READ, OP_WRITE: state_next = ST_ADDR;
                            OP_READ_ID:        state_next = ST_RDATA;
                            default:           state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rise && cnt == CW'(ADDR_BYTES - 1)) begin
                        if (op_q == OP_WRITE)       state_next = ST_WDATA;
                        else if (DUMMY_CYCLES == 0) state_next = ST_RDATA;
                        else                        state_next = ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    if (rise && cnt == CW'(DUMMY_CYCLES - 1)) state_next = ST_RDATA;
                end
                default: state_next = state;
            endcase
        end
    end

    // Per-cycle datapath actions derived from the current state and edges.
    always_comb begin
        shift_addr   = 1'b0;
        cnt_step     = 1'b0;
        rd_load      = 1'b0;
        wr_en        = 1'b0;
        enter_ignore = 1'b0;
        if (!cs_n) begin
            shift_addr   = (state == ST_ADDR) && rise;
            rd_load      = (state == ST_RDATA) && fall;
            wr_en        = (state == ST_WDATA) && rise;
            cnt_step     = ((state == ST_ADDR || state == ST_DUMMY) && rise) ||
                           (rd_load && op_q == OP_READ_ID && cnt < CW'(3));
            enter_ignore = (state == ST_CMD) && (state_next == ST_IGNORE);
        end
    end

    assign busy = (state != ST_IDLE);

    // Registered bus outputs, opcode, address and phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_q  <= 1'b1;
            op_q    <= 8'h00;
            addr    <= '0;
            cnt     <= '0;
            dq_o    <= 8'h00;
            dq_oe   <= 1'b0;
            dqs_o   <= 1'b0;
            dqs_oe  <= 1'b0;
            err_cmd <= 1'b0;
        end else begin
            cs_n_q  <= cs_n;
            err_cmd <= enter_ignore;
            if (cs_n) begin
                addr   <= '0;
                cnt    <= '0;
                dq_oe  <= 1'b0;
                dqs_o  <= 1'b0;
                dqs_oe <= 1'b0;
            end else begin
                if (state_next != state) cnt <= '0;
                else if (cnt_step)       cnt <= cnt + CW'(1);
                if (state == ST_CMD && rise) op_q <= dq_i;
                // Only the low address bits survive the shift; upper bytes fall off.
                if (shift_addr) addr <= AW'({addr, dq_i});
                if (rd_load) begin
                    dq_o   <= (op_q == OP_READ_ID) ? id_byte(DEVICE_ID, cnt) : mem[addr];
                    dq_oe  <= 1'b1;
                    dqs_oe <= 1'b1;
                    dqs_o  <= ~dqs_o;
                    if (op_q == OP_READ) addr <= addr + AW'(1);
                end
                if (wr_en) addr <= addr + AW'(1);
            end
        end
    end

    // Memory write port; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= dq_i;
    end

endmodule

// File: tb/tb_ospi_target.sv
// Self-checking bench for ospi_target: directed write/read table, READ_ID,
// bad opcode, cs_n abort, async reset mid-write and randomized traffic
// against a byte-array model of the target memory.
module tb_ospi_target;

  localparam int DEPTH = 256;
  localparam int DUMMY = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b0;
  logic [7:0] dq_i = 8'h00;
  logic [7:0] dq_o;
  logic       dq_oe;
  logic       dqs_o;
  logic       dqs_oe;
  logic       err_cmd;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [DEPTH];

  int err_cnt = 0;
  int oe_cnt = 0;

  typedef struct {
    logic [31:0] wr_addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [31:0] rd_addr;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t tbl [5];

  ospi_target dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .dq_i    (dq_i),
    .dq_o    (dq_o),
    .dq_oe   (dq_oe),
    .dqs_o   (dqs_o),
    .dqs_oe  (dqs_oe),
    .err_cmd (err_cmd),
    .busy    (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_cmd) err_cnt <= err_cnt + 1;
    if (dq_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks: all leave time at posedge+1
  task automatic pulse(input logic [7:0] b);
    dq_i = b;
    sclk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sclk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] a);
    frame_begin();
    pulse(op);
    for (int i = 0; i < 4; i++) pulse(a[31-8*i -: 8]);
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [7:0] data_q[$]);
    send_hdr(8'h02, a);
    foreach (data_q[i]) begin
      pulse(data_q[i]);
      ref_mem[8'(a[7:0] + 8'(i))] = data_q[i];
    end
    frame_end();
  endtask

  // scoreboard: compares each returned byte and strobe phase with exp_q
  task automatic read_check(input logic [31:0] a, input logic [7:0] exp_q[$], input string nm);
    send_hdr(8'h0B, a);
    repeat (DUMMY) pulse(8'h00);
    foreach (exp_q[i]) begin
      if (i > 0) pulse(8'h00);
      check({nm, "_dq"}, {24'h0, dq_o}, {24'h0, exp_q[i]});
      check({nm, "_dqs"}, {31'h0, dqs_o}, {31'h0, ~i[0]});
      check({nm, "_oe"}, {30'h0, dq_oe, dqs_oe}, 32'h3);
    end
    frame_end();
    check({nm, "_oe_end"}, {30'h0, dq_oe, dqs_oe}, 32'h0);
  endtask

  task automatic model_read(input logic [31:0] a, input int n, output logic [7:0] exp_q[$]);
    exp_q = {};
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(int'(a[7:0]) + i) % DEPTH]);
  endtask

  task automatic read_id_check(input string nm);
    logic [7:0] id_exp [5];
    id_exp = '{8'hC2, 8'h85, 8'h3A, 8'h00, 8'h00};
    frame_begin();
    check({nm, "_oe_pre"}, {31'h0, dq_oe}, 32'h0);
    pulse(8'h9F);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) pulse(8'h00);
      check({nm, "_dq"}, {24'h0, dq_o}, {24'h0, id_exp[i]});
      check({nm, "_dqs"}, {31'h0, dqs_o}, {31'h0, ~i[0]});
      check({nm, "_oe"}, {31'h0, dq_oe}, 32'h1);
    end
    frame_end();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e[$];
    int base_err;
    int base_oe;

    tbl[0] = '{32'h0000_0010, 8'hA5, 8'h5A, 32'h0000_0010, 8'hA5, 8'h5A};
    tbl[1] = '{32'h0000_00FF, 8'h11, 8'h22, 32'h0000_00FF, 8'h11, 8'h22};
    tbl[2] = '{32'h0000_00FE, 8'h33, 8'h44, 32'h0000_00FF, 8'h44, 8'h22};
    tbl[3] = '{32'h1234_5680, 8'hC3, 8'h3C, 32'h0000_0080, 8'hC3, 8'h3C};
    tbl[4] = '{32'h0000_007F, 8'h00, 8'hFF, 32'hFFFF_FF7F, 8'h00, 8'hFF};

    // reset state
    #2;
    check("rst_async", {26'h0, dq_o[3:0], dq_oe, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {dq_o, 4'h0, dq_oe, dqs_o, dqs_oe, err_cmd, 15'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", {31'h0, busy}, 32'h0);

    // give every location a known value
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
    write_frame(32'h0, q);

    // directed write/read table
    for (int t = 0; t < 5; t++) begin
      write_frame(tbl[t].wr_addr, '{tbl[t].d0, tbl[t].d1});
      e = '{tbl[t].e0, tbl[t].e1};
      read_check(tbl[t].rd_addr, e, $sformatf("tbl%0d", t));
    end
    // wrapped byte at 0x00 after writing 0xFF,0x00
    write_frame(32'hFF, '{8'h11, 8'h22});
    read_check(32'h0, '{8'h22}, "wrap0");

    // READ_ID
    read_id_check("rdid");

    // unsupported opcode
    base_err = err_cnt;
    base_oe = oe_cnt;
    frame_begin();
    pulse(8'h66);
    pulse(8'h0B);
    pulse(8'h12);
    check("bad_busy", {31'h0, busy}, 32'h1);
    check("bad_err_cnt", 32'(err_cnt - base_err), 32'h1);
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    check("bad_busy_drop", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("bad_oe_cnt", 32'(oe_cnt - base_oe), 32'h0);

    // cs_n abort after one read byte
    send_hdr(8'h0B, 32'h10);
    repeat (DUMMY) pulse(8'h00);
    check("abort_dq", {24'h0, dq_o}, {24'h0, ref_mem[8'h10]});
    check("abort_oe_pre", {31'h0, dq_oe}, 32'h1);
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_oe", {29'h0, dq_oe, dqs_oe, dqs_o}, 32'h0);
    check("abort_idle", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    read_id_check("rdid2");

    // async reset mid-write
    send_hdr(8'h02, 32'h40);
    pulse(8'h77);
    ref_mem[8'h40] = 8'h77;
    pulse(8'h88);
    ref_mem[8'h41] = 8'h88;
    dq_i = 8'h99;
    sclk = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {dq_o, 4'h0, dq_oe, dqs_o, dqs_oe, err_cmd, 15'h0, busy}, 32'h0);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_read(32'h40, 3, e);
    read_check(32'h40, e, "rst_keep");

    // randomized traffic against the memory model
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      int n;
      a = {8'($urandom), 16'($urandom), 8'($urandom_range(0, 255))};
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        write_frame(a, q);
      end else begin
        model_read(a, n, e);
        read_check(a, e, $sformatf("rnd%0d", it));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
